// File: rtl/stepper_pkg.sv
// stepper_pkg: shared types and helpers for the multi-axis stepper pulse generator.
//   - STEP_W_DEFAULT : default width of a signed-magnitude step word
//   - state_t        : move sequencer states
//   - sm_split       : splits a signed-magnitude word into direction and magnitude
//   - axis_sign      : motion sign of the sum of two signed-magnitude values as a 2-bit code
package stepper_pkg;

    localparam int STEP_W_DEFAULT = 32;
    // Widest step word the helpers accept; narrower words are zero-extended into it.
    localparam int SM_MAX_W = 64;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    typedef struct packed {
        logic                dir;
        logic [SM_MAX_W-1:0] mag;
    } sm_t;

    localparam sm_t SM_ZERO = '0;

    // Axis motion codes: two's-complement -1/0/+1 in two bits.
    localparam logic [1:0] MOVE_NONE = 2'b00;
    localparam logic [1:0] MOVE_POS  = 2'b01;
    localparam logic [1:0] MOVE_NEG  = 2'b11;

    function automatic sm_t sm_split(input logic [SM_MAX_W-1:0] word, input int unsigned width);
        sm_t                 r;
        logic [SM_MAX_W-1:0] msb;
        msb   = SM_MAX_W'(1) << (width - 1);
        r.dir = |(word & msb);
        r.mag = word & (msb - SM_MAX_W'(1));
        return r;
    endfunction

    function automatic logic [1:0] dir_code(input logic dir);
        return dir ? MOVE_NEG : MOVE_POS;
    endfunction

    // Sign of (a + b) worked out in sign-magnitude form, so no wide adder is needed.
    // A zero magnitude contributes nothing regardless of its direction bit.
    function automatic logic [1:0] axis_sign(input sm_t a, input sm_t b);
        if (a.mag == '0 && b.mag == '0) return MOVE_NONE;
        if (b.mag == '0)                return dir_code(a.dir);
        if (a.mag == '0)                return dir_code(b.dir);
        if (a.dir == b.dir)             return dir_code(a.dir);
        if (a.mag > b.mag)              return dir_code(a.dir);
        if (b.mag > a.mag)              return dir_code(b.dir);
        return MOVE_NONE;
    endfunction

endpackage

// File: rtl/stepper_channel.sv
// stepper_channel: one STEP pulse train generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : latch mag_in / half_in and start the train (first STEP high next cycle)
//   stop       : end the train now; a STEP that is currently high counts as completed
//   mag_in     : number of pulses to emit
//   half_in    : half-period in clk cycles (0 behaves as 1)
//   active     : channel still has phase time left after the current cycle
//   step       : STEP output
//   mag        : pulses not yet completed
module stepper_channel #(
    parameter int MAG_W = 31,
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             stop,
    input  logic [MAG_W-1:0] mag_in,
    input  logic [DIV_W-1:0] half_in,
    output logic             active,
    output logic             step,
    output logic [MAG_W-1:0] mag
);

    logic [DIV_W-1:0] reload;
    logic [DIV_W-1:0] cnt;
    logic             run;
    logic             last_phase;

    // The trailing low half of the final pulse still counts as active time; the
    // channel retires when that half expires with nothing left to emit.
    assign last_phase = (cnt == '0) && !step && (mag == '0);
    assign active     = run && !last_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload <= '0;
            cnt    <= '0;
            run    <= 1'b0;
            step   <= 1'b0;
            mag    <= '0;
        end else if (load) begin
            reload <= (half_in == '0) ? '0 : half_in - DIV_W'(1);
            cnt    <= (half_in == '0) ? '0 : half_in - DIV_W'(1);
            mag    <= mag_in;
            step   <= |mag_in;
            run    <= |mag_in;
        end else if (run) begin
            if (stop) begin
                run  <= 1'b0;
                step <= 1'b0;
                if (step) mag <= mag - MAG_W'(1);
            end else if (cnt == '0) begin
                cnt <= reload;
                if (step) begin
                    step <= 1'b0;
                    mag  <= mag - MAG_W'(1);
                end else if (mag == '0) begin
                    run <= 1'b0;
                end else begin
                    step <= 1'b1;
                end
            end else begin
                cnt <= cnt - DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/stepper_multi_axis.sv
// stepper_multi_axis: N-channel STEP/DIR pulse generator with endstop gating.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : level; a rising edge while idle launches a move
//   abort       : stop request, honoured while busy
//   step_in     : per-channel signed-magnitude step count, channel i at [i*STEP_W +: STEP_W]
//   half_period : per-channel half-period in clk cycles, channel i at [i*DIV_W +: DIV_W]
//   end_min/max : per-axis endstops, active-high
//   step_out    : STEP pulses
//   dir_out     : direction latched at launch
//   remaining   : live signed-magnitude steps not yet completed
//   busy, done  : move in progress / one-cycle end-of-move pulse
//   halted      : last move ended by endstop or abort; cleared at the next launch
module stepper_multi_axis
    import stepper_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int STEP_W = STEP_W_DEFAULT,
    parameter int DIV_W  = 32,
    parameter int COREXY = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [N_CH*STEP_W-1:0]   step_in,
    input  logic [N_CH*DIV_W-1:0]    half_period,
    input  logic [N_CH-1:0]          end_min,
    input  logic [N_CH-1:0]          end_max,
    output logic [N_CH-1:0]          step_out,
    output logic [N_CH-1:0]          dir_out,
    output logic [N_CH*STEP_W-1:0]   remaining,
    output logic                     busy,
    output logic                     done,
    output logic                     halted
);

    localparam int MAG_W = STEP_W - 1;

    state_t                 state, state_nxt;
    logic                   start_d;
    logic                   start_rise;
    logic                   any_move;
    logic                   load;
    logic                   stop;
    logic                   halt_req;
    sm_t                    cmd [N_CH];
    sm_t                    cmd1_neg;
    logic [MAG_W-1:0]       cmd_mag [N_CH];
    logic [N_CH-1:0][1:0]   axis_nxt;
    logic [N_CH-1:0][1:0]   axis_mv;
    logic [N_CH-1:0]        blocked;
    logic [N_CH-1:0]        act;
    logic [MAG_W-1:0]       mag [N_CH];

    assign start_rise = start && !start_d;

    always_comb begin
        any_move = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            cmd[i]     = sm_split(SM_MAX_W'(step_in[i*STEP_W +: STEP_W]), STEP_W);
            cmd_mag[i] = MAG_W'(cmd[i].mag);
            any_move   = any_move | (cmd[i].mag != '0);
        end
    end

    // Axis motion is fixed at launch. With CoreXY, X follows a+b and Y follows a-b.
    always_comb begin
        axis_nxt     = '0;
        cmd1_neg     = cmd[1];
        cmd1_neg.dir = ~cmd[1].dir;
        for (int i = 0; i < N_CH; i++) begin
            axis_nxt[i] = axis_sign(cmd[i], SM_ZERO);
        end
        if (COREXY != 0) begin
            axis_nxt[0] = axis_sign(cmd[0], cmd[1]);
            axis_nxt[1] = axis_sign(cmd[0], cmd1_neg);
        end
    end

    // Only an endstop on the side the axis is heading towards blocks it.
    always_comb begin
        blocked = '0;
        for (int i = 0; i < N_CH; i++) begin
            blocked[i] = ((axis_mv[i] == MOVE_NEG) && end_min[i]) ||
                         ((axis_mv[i] == MOVE_POS) && end_max[i]);
        end
    end

    assign halt_req = abort || (|blocked);
    assign stop     = (state == RUN) && halt_req;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start_rise) begin
                    if (any_move) begin
                        state_nxt = RUN;
                        load      = 1'b1;
                    end else begin
                        state_nxt = FINISH;
                    end
                end
            end
            RUN: begin
                if (halt_req || !(|act)) state_nxt = FINISH;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            start_d <= 1'b0;
            dir_out <= '0;
            axis_mv <= '0;
            halted  <= 1'b0;
        end else begin
            state   <= state_nxt;
            start_d <= start;
            if (load) begin
                halted  <= 1'b0;
                axis_mv <= axis_nxt;
                for (int i = 0; i < N_CH; i++) begin
                    dir_out[i] <= cmd[i].dir;
                end
            end else if (stop) begin
                halted <= 1'b1;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == FINISH);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        stepper_channel #(
            .MAG_W (MAG_W),
            .DIV_W (DIV_W)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (load),
            .stop    (stop),
            .mag_in  (cmd_mag[g]),
            .half_in (half_period[g*DIV_W +: DIV_W]),
            .active  (act[g]),
            .step    (step_out[g]),
            .mag     (mag[g])
        );
        assign remaining[g*STEP_W +: STEP_W] = {dir_out[g], mag[g]};
    end

endmodule

// File: tb/tb_stepper_multi_axis.sv
// Testbench for stepper_multi_axis (N_CH=4, CoreXY on channels 0/1).
// Directed table of moves with hand-derived results, hand-written corner
// sequences, and randomized moves checked cycle by cycle against a closed-form
// model of the pulse train.
module tb_stepper_multi_axis;

    localparam int N  = 4;
    localparam int SW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [N*SW-1:0]   step_in = '0;
    logic [N*DW-1:0]   half_period = '0;
    logic [N-1:0]      end_min = '0;
    logic [N-1:0]      end_max = '0;
    logic [N-1:0]      step_out;
    logic [N-1:0]      dir_out;
    logic [N*SW-1:0]   remaining;
    logic              busy;
    logic              done;
    logic              halted;

    int n_vec = 0;
    int n_bad = 0;

    stepper_multi_axis #(
        .N_CH   (N),
        .STEP_W (SW),
        .DIV_W  (DW),
        .COREXY (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .step_in     (step_in),
        .half_period (half_period),
        .end_min     (end_min),
        .end_max     (end_max),
        .step_out    (step_out),
        .dir_out     (dir_out),
        .remaining   (remaining),
        .busy        (busy),
        .done        (done),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][30:0] mag;
        logic [3:0]       dir;
        logic [3:0][31:0] hp;
        int               h;
        logic             ab;
        logic [3:0]       emin;
        logic [3:0]       emax;
        int               exp_done;
        logic             exp_halted;
        logic [127:0]     exp_rem;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Closed-form pulse train: STEP is high during the first half of each
    // 2P-cycle period, counting from cycle 1 after launch.
    function automatic bit fstep(int m, int p, int t);
        return (t >= 1) && (t <= 2 * p * m) && ((((t - 1) / p) % 2) == 0);
    endfunction

    // A step is complete once its high half has ended.
    function automatic int fmag(int m, int p, int t);
        int r;
        r = m - (t - 1 + p) / (2 * p);
        return (r < 0) ? 0 : r;
    endfunction

    function automatic int sgn(int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    task automatic run_move(input logic [3:0][30:0] m, input logic [3:0] d,
                            input logic [3:0][31:0] hp, input int h, input logic ab,
                            input logic [3:0] emin, input logic [3:0] emax,
                            output int done_at, output logic hl, output logic [127:0] rem);
        int         p [4];
        int         mi [4];
        int         ai [4];
        int         ax [4];
        int         T;
        int         E;
        int         hc;
        bit         blk;
        bit         halt;
        logic [3:0] es;
        logic [10:0]  exp_ctl;
        logic [127:0] exp_rem;
        int         em;

        T = 0;
        for (int i = 0; i < 4; i++) begin
            p[i]  = (hp[i] == 0) ? 1 : int'(hp[i]);
            mi[i] = int'(m[i]);
            ai[i] = d[i] ? -mi[i] : mi[i];
            if (2 * p[i] * mi[i] > T) T = 2 * p[i] * mi[i];
        end
        ax[0] = sgn(ai[0] + ai[1]);
        ax[1] = sgn(ai[0] - ai[1]);
        ax[2] = sgn(ai[2]);
        ax[3] = sgn(ai[3]);
        blk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((ax[i] < 0 && emin[i]) || (ax[i] > 0 && emax[i])) blk = 1'b1;
        end
        halt = (h >= 1) && (h <= T) && (ab || blk);
        E    = halt ? h + 1 : T + 1;
        hc   = halt ? h : T;

        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            step_in[i*SW +: SW]     = {d[i], m[i]};
            half_period[i*DW +: DW] = hp[i];
        end
        start = 1'b1;
        done_at = -1;
        for (int t = 1; t <= E + 2; t++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (t < E) begin
                    es[i] = fstep(mi[i], p[i], t);
                    em    = fmag(mi[i], p[i], t);
                end else begin
                    es[i] = 1'b0;
                    em    = fmag(mi[i], p[i], hc) - ((halt && fstep(mi[i], p[i], hc)) ? 1 : 0);
                end
                exp_rem[i*32 +: 32] = {d[i], 31'(em)};
            end
            exp_ctl = {es, d, (t < E), (t == E), (t >= E) && halt};
            chk($sformatf("ctl t=%0d", t), 128'({step_out, dir_out, busy, done, halted}), 128'(exp_ctl));
            chk($sformatf("remaining t=%0d", t), remaining, exp_rem);
            if (done && done_at < 0) done_at = t;
            if (t == 1) start = 1'b0;
            if (t == h) begin
                abort   = ab;
                end_min = emin;
                end_max = emax;
            end
            if (t == h + 1) abort = 1'b0;
        end
        chk("done_cycle_model", 128'(done_at), 128'(E));
        abort   = 1'b0;
        end_min = '0;
        end_max = '0;
        hl  = halted;
        rem = remaining;
    endtask

    initial begin
        int           da;
        logic         hl;
        logic [127:0] rm;
        logic [3:0][30:0] m;
        logic [3:0]       d;
        logic [3:0][31:0] hp;
        int           h;
        int           mode;
        int           nd;
        bit           nb;
        bit           seen;

        for (int i = 0; i < NV; i++) vecs[i] = '0;
        // Two cartesian channels: +3 at P=2, -2 at P=4.
        vecs[0].mag[2] = 31'd3; vecs[0].hp[2] = 32'd2;
        vecs[0].mag[3] = 31'd2; vecs[0].dir[3] = 1'b1; vecs[0].hp[3] = 32'd4;
        vecs[0].exp_done = 17;
        vecs[0].exp_rem  = {32'h8000_0000, 32'h0, 32'h0, 32'h0};
        // CoreXY -5/-5, X moving negative, end_min[0] raised while STEP is high.
        vecs[1].mag[0] = 31'd5; vecs[1].dir[0] = 1'b1; vecs[1].hp[0] = 32'd3;
        vecs[1].mag[1] = 31'd5; vecs[1].dir[1] = 1'b1; vecs[1].hp[1] = 32'd3;
        vecs[1].h = 7; vecs[1].emin = 4'b0001;
        vecs[1].exp_done = 8; vecs[1].exp_halted = 1'b1;
        vecs[1].exp_rem  = {32'h0, 32'h0, 32'h8000_0003, 32'h8000_0003};
        // Same move, endstop on the opposite side: no stop.
        vecs[2] = vecs[1];
        vecs[2].emin = 4'b0000; vecs[2].emax = 4'b0001;
        vecs[2].exp_done = 31; vecs[2].exp_halted = 1'b0;
        vecs[2].exp_rem  = {32'h0, 32'h0, 32'h8000_0000, 32'h8000_0000};
        // Y = a-b is zero, so neither Y endstop blocks.
        vecs[3] = vecs[2];
        vecs[3].emin = 4'b0010; vecs[3].emax = 4'b0010;
        // Abort while ch0 STEP is high with magnitude 4.
        vecs[4].mag[0] = 31'd4; vecs[4].hp[0] = 32'd2;
        vecs[4].h = 1; vecs[4].ab = 1'b1;
        vecs[4].exp_done = 2; vecs[4].exp_halted = 1'b1;
        vecs[4].exp_rem  = {32'h0, 32'h0, 32'h0, 32'h0000_0003};
        // Half-period 0 behaves as 1.
        vecs[5].mag[1] = 31'd2; vecs[5].hp[1] = 32'd0;
        vecs[5].exp_done = 5;
        vecs[5].exp_rem  = '0;

        #1;
        chk("reset_ctl", 128'({step_out, dir_out, busy, done, halted}), 128'(0));
        chk("reset_remaining", remaining, '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < NV; v++) begin
            run_move(vecs[v].mag, vecs[v].dir, vecs[v].hp, vecs[v].h, vecs[v].ab,
                     vecs[v].emin, vecs[v].emax, da, hl, rm);
            chk($sformatf("vec%0d done_cycle", v), 128'(da), 128'(vecs[v].exp_done));
            chk($sformatf("vec%0d halted", v), 128'(hl), 128'(vecs[v].exp_halted));
            chk($sformatf("vec%0d remaining", v), rm, vecs[v].exp_rem);
        end

        // start held high past done must not relaunch.
        @(negedge clk);
        step_in = '0;
        step_in[0 +: SW] = 32'd1;
        half_period = '0;
        start = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("held_start_done_seen", 128'(seen), 128'(1));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("held_start_no_relaunch", 128'({busy, done}), 128'(0));
        end
        start = 1'b0;

        // All magnitudes zero (one negative zero): no launch, one done pulse.
        @(negedge clk);
        step_in = '0;
        step_in[0 +: SW] = 32'h8000_0000;
        start = 1'b1;
        nd = 0;
        nb = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) nd++;
            if (busy) nb = 1'b1;
            start = 1'b0;
        end
        chk("zero_move_done_count", 128'(nd), 128'(1));
        chk("zero_move_busy", 128'(nb), 128'(0));

        // Randomized moves against the model.
        for (int r = 0; r < 24; r++) begin
            m = '0; d = '0; hp = '0;
            for (int i = 0; i < 4; i++) begin
                m[i]  = 31'($urandom_range(0, 4));
                d[i]  = 1'($urandom_range(0, 1));
                hp[i] = 32'($urandom_range(0, 3));
            end
            if (m == '0) m[$urandom_range(0, 3)] = 31'd1;
            mode = $urandom_range(0, 2);
            h = (mode == 0) ? 0 : $urandom_range(1, 30);
            run_move(m, d, hp, h, (mode == 1),
                     (mode == 2) ? 4'($urandom_range(0, 15)) : 4'b0,
                     (mode == 2) ? 4'($urandom_range(0, 15)) : 4'b0, da, hl, rm);
        end

        // Asynchronous reset in the middle of a move, then a normal relaunch.
        @(negedge clk);
        step_in = '0;
        step_in[0 +: SW] = 32'd4;
        half_period = '0;
        half_period[0 +: DW] = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_ctl", 128'({step_out, dir_out, busy, done, halted}), 128'(0));
        chk("async_reset_remaining", remaining, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_move(vecs[0].mag, vecs[0].dir, vecs[0].hp, 0, 1'b0, 4'b0, 4'b0, da, hl, rm);
        chk("after_reset done_cycle", 128'(da), 128'(17));
        chk("after_reset remaining", rm, vecs[0].exp_rem);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
